z80_bus_sequencer: RTL
======================

Name: z80_bus_sequencer

Overview:
Machine-cycle (M-cycle) sequencer for the Z80 external bus. It accepts one bus-cycle request at a time from the core control logic and drives the address, data and control pins T-state by T-state. Cycle types are opcode fetch with refresh, memory read/write, and I/O read/write. It also owns the R refresh counter and the BUSREQ/BUSACK bus-grant handshake. It sits between the decoder/sequencer and the pad ring. Modelling: one CLK edge = one T-state.

Parameters:
IO_WAITS, 1, automatic Tw states inserted in I/O cycles after T2 (0..3)
R_BITS, 7, width of auto-incrementing part of R; remaining bits of R are preserved

Ports:
CLK  in  1  clock; all state changes on rising edge
RESET  in  1  synchronous active-high reset
cyc_start  in  1  request a bus cycle; accepted only when ready=1
cyc_type  in  3  0=M1 fetch, 1=mem read, 2=mem write, 3=io read, 4=io write; 5-7 reserved
cyc_addr  in  16  cycle address, captured on accept
cyc_wdata  in  8  write data, captured on accept
ready  out  1  =(state==IDLE) & n_BUSREQ (combinational)
done  out  1  one-clock pulse in final T-state of a cycle
rdata  out  8  data captured on read/fetch, held until next read
i_reg  in  8  I register; upper byte of refresh address
r_load  in  1  load R from r_in (LD R,A)
r_in  in  8  R load value
r_out  out  8  current R
A  out  16  address bus
A_OE  out  1  address drive enable
D_IN  in  8  data bus input
D_OUT  out  8  data bus output
D_OE  out  1  data drive enable
n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH  out  1 each  active-low strobes
CTL_OE  out  1  control strobe drive enable (0 during bus grant)
n_WAIT  in  1  wait request, active-low
n_BUSREQ  in  1  bus request, active-low
n_BUSACK  out  1  bus acknowledge, active-low

Behaviour:
- Reset (RESET=1 at edge): state IDLE; all n_* outputs 1; A=0, A_OE=1, CTL_OE=1, D_OE=0, D_OUT=0, rdata=0, R=0, done=0. Reset aborts any cycle in progress at that edge, including bus grant.
- States: IDLE, T1, T2, TWA (automatic I/O wait), TW (external wait), T3, T4, GRANT.
- IDLE: if n_BUSREQ=0 -> GRANT. Otherwise, if cyc_start and type 0-4 -> T1 with addr/wdata/type latched. Reserved types are ignored: no cycle, no done. BUSREQ wins over a simultaneous cyc_start, since ready=0 in that case.
- M1 fetch:
  - T1/T2: A=addr, n_M1=0, n_MREQ=0, n_RD=0.
  - n_WAIT is sampled at the end of T2 and at the end of each TW; 0 -> TW.
  - Entering T3: rdata<=D_IN. n_M1 and n_RD go 1.
  - T3: A={i_reg, R}, n_RFSH=0, n_MREQ=0.
  - T4: A={i_reg, R}, n_RFSH=0, n_MREQ=1, done=1.
  - At the end of T4, R[R_BITS-1:0] increments mod 2^R_BITS; R[7] is unchanged.
  - Length 4 + waits.
- Mem read:
  - T1-T3: n_MREQ=0, n_RD=0.
  - Wait sampling as for M1.
  - rdata<=D_IN at the end of T3; done in T3.
  - Length 3 + waits.
- Mem write:
  - T1: n_MREQ=0, D_OE=1, D_OUT=wdata.
  - T2/TW/T3: n_WR=0 in addition.
  - D_OE stays 1 through T3; done in T3.
- I/O read/write:
  - T1: address only.
  - T2, IO_WAITS x TWA, TW*, T3: n_IORQ=0 with n_RD=0 or n_WR=0.
  - n_WAIT is sampled at the end of the last TWA, or at the end of T2 if IO_WAITS=0.
  - Read data is captured at the end of T3; the write drives D from T1 to T3.
  - Length 3 + IO_WAITS + waits.
- After T3/T4 -> IDLE. A back-to-back request gives T1 on the second edge (one IDLE cycle minimum).
- GRANT: n_BUSACK=0, A_OE=0, D_OE=0, CTL_OE=0, strobes held 1. Stays while n_BUSREQ=0. n_BUSREQ=1 sampled -> IDLE (n_BUSACK=1, enables restored on that edge). BUSREQ is not sampled during a cycle; the cycle always completes first.
- r_load is honoured in any state. It has priority over the M1 increment in the same clock.
- An unbounded n_WAIT=0 holds TW indefinitely. RESET is the only exit.

Test Plan:
- M1 fetch at 0x1234, n_WAIT=1, D_IN=0x3E, i_reg=0x80, R=0x05 -> 4 clocks. A=0x1234 with n_M1=n_RD=n_MREQ=0 for 2 clocks, then A=0x8005 with n_RFSH=0 for 2 clocks. rdata=0x3E, done in clock 4, R=0x06.
- Mem read with n_WAIT=0 for 2 samples -> 5 clocks. done is on clock 5. rdata equals D_IN at the end of clock 5.
- I/O write 0x00FE data 0xA5, IO_WAITS=1 -> 4 clocks. n_IORQ=n_WR=0 in clocks 2-4; D_OE=1 with D_OUT=0xA5 in clocks 1-4.
- R wrap: r_load 0xFF, then one fetch -> r_out=0x80. r_load and M1 increment in the same clock -> r_in wins.
- n_BUSREQ=0 asserted mid mem-read -> cycle completes, then GRANT. n_BUSACK=0, A_OE=D_OE=CTL_OE=0, ready=0. cyc_start is ignored. Releasing n_BUSREQ -> n_BUSACK=1 after 1 edge.
- RESET pulsed during TW of a write -> next edge: IDLE, all strobes 1, D_OE=0, no done, R=0.

Source files
------------

// File: rtl/z80_bus_sequencer.sv
// Z80 external bus M-cycle sequencer.
// Runs one bus cycle at a time (opcode fetch with refresh, memory read/write,
// I/O read/write), T-state by T-state, and owns the R refresh counter and the
// BUSREQ/BUSACK bus-grant handshake. One rising CLK edge is one T-state.
//
// Request handshake: a request is taken on a rising edge where cyc_start=1 and
// ready=1, and the address, write data and type are captured on that edge.
// ready is high only in IDLE with no bus request pending. done pulses for
// exactly one clock in the final T-state of the accepted cycle.
// Reserved cycle types (5-7) are dropped: no cycle and no done.
module z80_bus_sequencer #(
   parameter int IO_WAITS = 1,   // automatic Tw states after T2 in I/O cycles (0..3)
   parameter int R_BITS   = 7    // auto-incrementing low bits of R
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        cyc_start,
   input  logic [2:0]  cyc_type,
   input  logic [15:0] cyc_addr,
   input  logic [7:0]  cyc_wdata,
   output logic        ready,
   output logic        done,
   output logic [7:0]  rdata,
   input  logic [7:0]  i_reg,
   input  logic        r_load,
   input  logic [7:0]  r_in,
   output logic [7:0]  r_out,
   output logic [15:0] A,
   output logic        A_OE,
   input  logic [7:0]  D_IN,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   output logic        n_M1,
   output logic        n_MREQ,
   output logic        n_IORQ,
   output logic        n_RD,
   output logic        n_WR,
   output logic        n_RFSH,
   output logic        CTL_OE,
   input  logic        n_WAIT,
   input  logic        n_BUSREQ,
   output logic        n_BUSACK
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_T1    = 3'd1,
      S_T2    = 3'd2,
      S_TWA   = 3'd3,   // automatic I/O wait
      S_TW    = 3'd4,   // external wait (n_WAIT low)
      S_T3    = 3'd5,
      S_T4    = 3'd6,
      S_GRANT = 3'd7
   } state_t;

   localparam logic [2:0] CT_M1   = 3'd0;
   localparam logic [2:0] CT_MRD  = 3'd1;
   localparam logic [2:0] CT_MWR  = 3'd2;
   localparam logic [2:0] CT_IORD = 3'd3;
   localparam logic [2:0] CT_IOWR = 3'd4;

   // Index of the last automatic wait state; only meaningful when IO_WAITS > 0.
   localparam logic [1:0] LAST_TWA = (IO_WAITS > 0) ? 2'(IO_WAITS - 1) : 2'd0;

   state_t      state;
   state_t      state_next;
   logic [2:0]  type_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic [7:0]  r_q;
   logic [7:0]  r_inc;
   logic [1:0]  wait_cnt;

   logic        is_m1;
   logic        is_io;
   logic        is_rd_type;
   logic        accept;
   logic        wait_point;
   logic        cap_m1;
   logic        cap_rd;
   logic        in_access;
   logic        past_t1;

   assign is_m1      = (type_q == CT_M1);
   assign is_io      = (type_q == CT_IORD) || (type_q == CT_IOWR);
   assign is_rd_type = (type_q == CT_MRD) || (type_q == CT_IORD);

   assign ready  = (state == S_IDLE) && n_BUSREQ;
   assign accept = ready && cyc_start && (cyc_type <= CT_IOWR);

   assign rdata = rdata_q;
   assign r_out = r_q;
   assign D_OUT = wdata_q;

   // n_WAIT sample point that can leave the T2/TWA part of the cycle.
   assign wait_point = ((state == S_T2) && (!is_io || (IO_WAITS == 0))) ||
                       ((state == S_TWA) && (wait_cnt == LAST_TWA));

   // Fetch data is taken on the edge that enters T3; reads on the edge leaving T3.
   assign cap_m1 = is_m1 && ((state == S_T2) || (state == S_TW)) && (state_next == S_T3);
   assign cap_rd = is_rd_type && (state == S_T3);

   // Address/strobe phase of the cycle (refresh phase of a fetch excluded).
   assign in_access = (state == S_T1) || (state == S_T2) || (state == S_TWA) ||
                      (state == S_TW) || ((state == S_T3) && !is_m1);
   assign past_t1   = (state != S_T1);

   // R increment: only the low R_BITS wrap, the rest of R is kept.
   always_comb begin
      r_inc = r_q;
      r_inc[R_BITS-1:0] = r_q[R_BITS-1:0] + R_BITS'(1);
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (!n_BUSREQ)   state_next = S_GRANT;
            else if (accept) state_next = S_T1;
         end
         S_T1:    state_next = S_T2;
         S_T2: begin
            if (is_io && (IO_WAITS > 0)) state_next = S_TWA;
            else                         state_next = n_WAIT ? S_T3 : S_TW;
         end
         S_TWA: begin
            if (wait_point) state_next = n_WAIT ? S_T3 : S_TW;
         end
         S_TW:    state_next = n_WAIT ? S_T3 : S_TW;
         S_T3:    state_next = is_m1 ? S_T4 : S_IDLE;
         S_T4:    state_next = S_IDLE;
         S_GRANT: state_next = n_BUSREQ ? S_IDLE : S_GRANT;
         default: state_next = S_IDLE;
      endcase
   end

   // Pin decode from the current T-state and the captured cycle type.
   always_comb begin
      A        = 16'h0000;
      A_OE     = 1'b1;
      CTL_OE   = 1'b1;
      D_OE     = 1'b0;
      n_M1     = 1'b1;
      n_MREQ   = 1'b1;
      n_IORQ   = 1'b1;
      n_RD     = 1'b1;
      n_WR     = 1'b1;
      n_RFSH   = 1'b1;
      n_BUSACK = 1'b1;
      done     = 1'b0;
      if (in_access) begin
         A = addr_q;
         case (type_q)
            CT_M1: begin
               n_M1   = 1'b0;
               n_MREQ = 1'b0;
               n_RD   = 1'b0;
            end
            CT_MRD: begin
               n_MREQ = 1'b0;
               n_RD   = 1'b0;
            end
            CT_MWR: begin
               n_MREQ = 1'b0;
               D_OE   = 1'b1;
               n_WR   = !past_t1;
            end
            CT_IORD: begin
               n_IORQ = !past_t1;
               n_RD   = !past_t1;
            end
            CT_IOWR: begin
               D_OE   = 1'b1;
               n_IORQ = !past_t1;
               n_WR   = !past_t1;
            end
            default: ;
         endcase
         done = (state == S_T3);
      end else if (state == S_T3) begin
         // Fetch refresh, first half.
         A      = {i_reg, r_q};
         n_RFSH = 1'b0;
         n_MREQ = 1'b0;
      end else if (state == S_T4) begin
         // Fetch refresh, second half; end of the M1 cycle.
         A      = {i_reg, r_q};
         n_RFSH = 1'b0;
         done   = 1'b1;
      end else if (state == S_GRANT) begin
         A_OE     = 1'b0;
         CTL_OE   = 1'b0;
         n_BUSACK = 1'b0;
      end
   end

   // State register, request capture, wait counter, read data and R.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= S_IDLE;
         type_q   <= CT_M1;
         addr_q   <= 16'h0000;
         wdata_q  <= 8'h00;
         rdata_q  <= 8'h00;
         r_q      <= 8'h00;
         wait_cnt <= 2'd0;
      end else begin
         state <= state_next;
         if (accept) begin
            type_q  <= cyc_type;
            addr_q  <= cyc_addr;
            wdata_q <= cyc_wdata;
         end
         if (state == S_T2)       wait_cnt <= 2'd0;
         else if (state == S_TWA) wait_cnt <= wait_cnt + 2'd1;
         if (cap_m1 || cap_rd) rdata_q <= D_IN;
         if (r_load)               r_q <= r_in;
         else if (state == S_T4)   r_q <= r_inc;
      end
   end

endmodule
